// File: rtl/exe_wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, long-latency channel results, branch
// update, flush, and the merged register writeback port.
interface exe_wb_arbiter_if #(
   parameter int NUM_LL = 2,
   parameter int DATA_W = 64,
   parameter int BR_W   = 20,
   parameter int ROB_W  = 7,
   parameter int PDST_W = 7
);
   // single-cycle ALU result, never stalled
   logic                               fast_valid;
   logic [ROB_W-1:0]                   fast_rob_idx;
   logic [PDST_W-1:0]                  fast_pdst;
   logic [1:0]                         fast_dst_rtype;
   logic [DATA_W-1:0]                  fast_data;

   // long-latency channel results, one lane per channel
   logic [NUM_LL-1:0]                  ll_valid;
   logic [NUM_LL-1:0]                  ll_ready;
   logic [NUM_LL-1:0][BR_W-1:0]        ll_br_mask;
   logic [NUM_LL-1:0][ROB_W-1:0]       ll_rob_idx;
   logic [NUM_LL-1:0][PDST_W-1:0]      ll_pdst;
   logic [NUM_LL-1:0][1:0]             ll_dst_rtype;
   logic [NUM_LL-1:0][DATA_W-1:0]      ll_data;

   // branch resolution and pipeline flush
   logic [BR_W-1:0]                    brupdate_resolve_mask;
   logic [BR_W-1:0]                    brupdate_mispredict_mask;
   logic                               flush;

   // merged writeback
   logic                               wb_valid;
   logic [ROB_W-1:0]                   wb_rob_idx;
   logic [PDST_W-1:0]                  wb_pdst;
   logic [1:0]                         wb_dst_rtype;
   logic [DATA_W:0]                    wb_data;
   logic [NUM_LL-1:0]                  busy;

   modport master (
      output fast_valid, fast_rob_idx, fast_pdst, fast_dst_rtype, fast_data,
      output ll_valid, ll_br_mask, ll_rob_idx, ll_pdst, ll_dst_rtype, ll_data,
      output brupdate_resolve_mask, brupdate_mispredict_mask, flush,
      input  ll_ready, wb_valid, wb_rob_idx, wb_pdst, wb_dst_rtype, wb_data, busy
   );

   modport slave (
      input  fast_valid, fast_rob_idx, fast_pdst, fast_dst_rtype, fast_data,
      input  ll_valid, ll_br_mask, ll_rob_idx, ll_pdst, ll_dst_rtype, ll_data,
      input  brupdate_resolve_mask, brupdate_mispredict_mask, flush,
      output ll_ready, wb_valid, wb_rob_idx, wb_pdst, wb_dst_rtype, wb_data, busy
   );
endinterface

// File: rtl/exe_wb_arbiter.sv
// Writeback merger: the ALU owns the writeback port whenever it has a result;
// long-latency results are parked in per-channel FIFOs that track branch masks
// and drain round-robin into idle writeback slots.

// Per-channel result FIFO with branch-mask tracking. Entries hit by a
// mispredict are marked dead and drained without writeback.
module exe_wb_ll_fifo #(
   parameter int DEPTH = 2,
   parameter int BR_W  = 20,
   parameter int PLD_W = 80
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enq_valid,
   input  logic [BR_W-1:0]  enq_mask,
   input  logic [PLD_W-1:0] enq_pld,
   input  logic [BR_W-1:0]  resolve_mask,
   input  logic [BR_W-1:0]  mispredict_mask,
   input  logic             flush,
   input  logic             grant,
   output logic             ready,
   output logic             head_live,
   output logic [PLD_W-1:0] head_pld,
   output logic             busy
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

   logic [DEPTH-1:0][PLD_W-1:0] pld_q;
   logic [DEPTH-1:0][BR_W-1:0]  mask_q;
   logic [DEPTH-1:0]            live_q;
   logic [PTR_W-1:0]            rd_ptr, wr_ptr;
   logic [CNT_W-1:0]            count;
   logic                        nonempty, enq, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   // Ready is a pure occupancy test so the producer never sees a
   // combinational path from the dequeue side.
   assign nonempty  = (count != '0);
   assign ready     = reset && (count < DEPTH_C);
   assign busy      = nonempty;
   assign head_pld  = pld_q[rd_ptr];
   // A head killed this very cycle is already treated as dead.
   assign head_live = nonempty && live_q[rd_ptr] && !(|(mask_q[rd_ptr] & mispredict_mask));
   assign enq       = enq_valid && ready && !flush && !(|(enq_mask & mispredict_mask));
   // Dead heads drain on their own, independent of who owns writeback.
   assign pop       = nonempty && (grant || !head_live);

   // Pointers, occupancy, and per-entry mask/live tracking.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         live_q <= '0;
         mask_q <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         live_q <= '0;
         mask_q <= '0;
      end else begin
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (enq) wr_ptr <= ptr_inc(wr_ptr);
         count <= count + CNT_W'(enq) - CNT_W'(pop);
         for (int e = 0; e < DEPTH; e++) begin
            if (|(mask_q[e] & mispredict_mask)) live_q[e] <= 1'b0;
            else                                mask_q[e] <= mask_q[e] & ~resolve_mask;
         end
         if (enq) begin
            live_q[wr_ptr] <= 1'b1;
            mask_q[wr_ptr] <= enq_mask & ~resolve_mask;
         end
      end
   end

   // Result payload storage; needs no reset since occupancy guards it.
   always_ff @(posedge clock) begin
      if (enq) pld_q[wr_ptr] <= enq_pld;
   end

   a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset) !(pop && !nonempty));
   a_no_enq_full:  assert property (@(posedge clock) disable iff (!reset) !(enq && count == DEPTH_C));
endmodule

module exe_wb_arbiter #(
   parameter int NUM_LL    = 2,
   parameter int BUF_DEPTH = 2,
   parameter int DATA_W    = 64,
   parameter int BR_W      = 20,
   parameter int ROB_W     = 7,
   parameter int PDST_W    = 7
) (
   input logic           clock,
   input logic           reset,
   exe_wb_arbiter_if.slave bus
);
   localparam int PLD_W = ROB_W + PDST_W + 2 + DATA_W;
   localparam int RR_W  = (NUM_LL > 1) ? $clog2(NUM_LL) : 1;
   localparam logic [RR_W:0]   NUM_LL_C = (RR_W + 1)'(NUM_LL);
   localparam logic [RR_W-1:0] LAST_CH  = RR_W'(NUM_LL - 1);

   typedef struct packed {
      logic [ROB_W-1:0]  rob_idx;
      logic [PDST_W-1:0] pdst;
      logic [1:0]        dst_rtype;
      logic [DATA_W-1:0] data;
   } wb_uop_t;

   logic [NUM_LL-1:0][PLD_W-1:0] enq_pld, head_pld;
   logic [NUM_LL-1:0]            head_live, grant;
   logic [RR_W-1:0]              rr_ptr, win_idx;
   logic [RR_W:0]                cand;
   logic                         found, ll_win;
   wb_uop_t                      win_uop;

   for (genvar i = 0; i < NUM_LL; i++) begin : g_ch
      assign enq_pld[i] = {bus.ll_rob_idx[i], bus.ll_pdst[i], bus.ll_dst_rtype[i], bus.ll_data[i]};

      exe_wb_ll_fifo #(
         .DEPTH (BUF_DEPTH),
         .BR_W  (BR_W),
         .PLD_W (PLD_W)
      ) u_fifo (
         .clock           (clock),
         .reset           (reset),
         .enq_valid       (bus.ll_valid[i]),
         .enq_mask        (bus.ll_br_mask[i]),
         .enq_pld         (enq_pld[i]),
         .resolve_mask    (bus.brupdate_resolve_mask),
         .mispredict_mask (bus.brupdate_mispredict_mask),
         .flush           (bus.flush),
         .grant           (grant[i]),
         .ready           (bus.ll_ready[i]),
         .head_live       (head_live[i]),
         .head_pld        (head_pld[i]),
         .busy            (bus.busy[i])
      );
   end

   // Round-robin pick among live heads, starting at rr_ptr; the ALU and
   // flush both suppress any long-latency grant.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      grant   = '0;
      for (int k = 0; k < NUM_LL; k++) begin
         cand = {1'b0, rr_ptr} + (RR_W + 1)'(k);
         if (cand >= NUM_LL_C) cand = cand - NUM_LL_C;
         if (!found && head_live[cand[RR_W-1:0]]) begin
            found   = 1'b1;
            win_idx = cand[RR_W-1:0];
         end
      end
      ll_win = found && !bus.fast_valid && !bus.flush;
      if (ll_win) grant[win_idx] = 1'b1;
   end

   // Writeback mux: ALU result has absolute priority.
   always_comb begin
      win_uop          = wb_uop_t'(head_pld[win_idx]);
      bus.wb_valid     = bus.fast_valid || ll_win;
      bus.wb_rob_idx   = win_uop.rob_idx;
      bus.wb_pdst      = win_uop.pdst;
      bus.wb_dst_rtype = win_uop.dst_rtype;
      bus.wb_data      = {1'b0, win_uop.data};
      if (bus.fast_valid) begin
         bus.wb_rob_idx   = bus.fast_rob_idx;
         bus.wb_pdst      = bus.fast_pdst;
         bus.wb_dst_rtype = bus.fast_dst_rtype;
         bus.wb_data      = {1'b0, bus.fast_data};
      end
   end

   // Round-robin pointer advances past each granted channel.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)          rr_ptr <= '0;
      else if (bus.flush)  rr_ptr <= '0;
      else if (ll_win)     rr_ptr <= (win_idx == LAST_CH) ? '0 : win_idx + 1'b1;
   end

   a_wb_msb_zero: assert property (@(posedge clock) disable iff (!reset) !bus.wb_data[DATA_W]);
endmodule
